// File: rtl/tdc_pkg.sv
// Shared constants and types for the TDC report scheduler: frame sync bytes,
// frame lengths, the scheduler state encoding and a byte-fold helper.
package tdc_pkg;

  localparam logic [7:0] SYNC_MEAS      = 8'hA5;
  localparam logic [7:0] SYNC_STAT      = 8'h5A;
  localparam int         MEAS_FRAME_LEN = 6;
  localparam int         STAT_FRAME_LEN = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  // XOR of the four bytes of a 32-bit word, used for the frame checksum.
  function automatic logic [7:0] xor_bytes(input logic [31:0] word);
    return word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
  endfunction

endpackage

// File: rtl/tdc_report_scheduler_if.sv
// Measurement input, UART byte handshake and status signals of the report
// scheduler. The scheduler uses the slave side; the TDC core / UART side is
// the master.
interface tdc_report_scheduler_if;

  logic        meas_valid;
  logic [31:0] meas_period;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] drop_count;

  modport master (
    output meas_valid, meas_period, tx_ready,
    input  tx_data, tx_valid, busy, drop_count
  );

  modport slave (
    input  meas_valid, meas_period, tx_ready,
    output tx_data, tx_valid, busy, drop_count
  );

endinterface

// File: rtl/tdc_tick_gen.sv
// Free-running period counter. Counts 0..PERIOD-1 and wraps; tick is high
// for exactly the wrap cycle (count == PERIOD-1).
module tdc_tick_gen #(
  parameter int PERIOD = 100_000_000
) (
  input  logic clk_100m,
  input  logic rst_n,
  output logic tick
);

  localparam int             W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0]   LAST = W'(PERIOD - 1);

  logic [W-1:0] count;

  // period counter, returns to zero after the terminal count
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)             count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + W'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/tdc_report_scheduler.sv
// Frames TDC period measurements and a periodic status (drop counter) report
// onto a single UART byte channel. One-entry holding register in front of a
// shift-out frame buffer; a heartbeat request is forced through after
// MAX_CONSEC back-to-back measurement frames.
//
// state | meaning
// IDLE  | arbitrate between pending heartbeat and held measurement
// LOAD  | snapshot the selected frame and its checksum into the frame buffer
// SEND  | present bytes MSB first, advance on tx_ready
module tdc_report_scheduler
  import tdc_pkg::*;
#(
  parameter int HB_CYCLES  = 100_000_000,
  parameter int MAX_CONSEC = 8
) (
  input  logic                  clk_100m,
  input  logic                  rst_n,
  tdc_report_scheduler_if.slave bus
);

  localparam int            CW         = $clog2(MAX_CONSEC + 1);
  localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_CONSEC);
  localparam logic [2:0]    MEAS_LAST  = 3'(MEAS_FRAME_LEN - 1);
  localparam logic [2:0]    STAT_LAST  = 3'(STAT_FRAME_LEN - 1);

  state_t        state;
  logic          hold_full;
  logic [31:0]   hold_data;
  logic          hb_pending;
  logic [CW-1:0] consec;
  logic          load_stat;
  logic [47:0]   frame_buf;
  logic [2:0]    idx;
  logic          tx_valid_q;
  logic          busy_q;
  logic [15:0]   drop_q;

  logic          tick;
  logic          hold_free;
  logic          take;
  logic          drop;
  logic [2:0]    last_idx;

  tdc_tick_gen #(.PERIOD(HB_CYCLES)) u_tick_gen (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .tick     (tick)
  );

  // The holding register is freed by a measurement LOAD; a measurement
  // arriving in that same cycle refills it instead of being dropped.
  assign hold_free = (state == LOAD) && !load_stat;
  assign take      = bus.meas_valid && (!hold_full || hold_free);
  assign drop      = bus.meas_valid && !take;
  assign last_idx  = load_stat ? STAT_LAST : MEAS_LAST;

  assign bus.tx_data    = frame_buf[47:40];
  assign bus.tx_valid   = tx_valid_q;
  assign bus.busy       = busy_q;
  assign bus.drop_count = drop_q;

  // holding register, drop counter, heartbeat request and framing FSM
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_full  <= 1'b0;
      hold_data  <= '0;
      hb_pending <= 1'b0;
      consec     <= '0;
      load_stat  <= 1'b0;
      frame_buf  <= '0;
      idx        <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;

      if (take) begin
        hold_data <= bus.meas_period;
        hold_full <= 1'b1;
      end else if (hold_free) begin
        hold_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          // A measurement arriving into an empty register is scheduled in the
          // same cycle it is captured, so the first byte appears two cycles
          // after meas_valid.
          if (hb_pending && (consec == CONSEC_MAX || !hold_full)) begin
            load_stat <= 1'b1;
            busy_q    <= 1'b1;
            state     <= LOAD;
          end else if (hold_full || bus.meas_valid) begin
            load_stat <= 1'b0;
            busy_q    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (load_stat) begin
            frame_buf  <= {SYNC_STAT, drop_q,
                           SYNC_STAT ^ drop_q[15:8] ^ drop_q[7:0], 16'h0000};
            drop_q     <= drop ? 16'd1 : 16'd0;
            hb_pending <= 1'b0;
            consec     <= '0;
          end else begin
            frame_buf <= {SYNC_MEAS, hold_data, SYNC_MEAS ^ xor_bytes(hold_data)};
            if (consec != CONSEC_MAX) consec <= consec + CW'(1);
          end
          idx        <= '0;
          tx_valid_q <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (bus.tx_ready) begin
            frame_buf <= {frame_buf[39:0], 8'h00};
            if (idx == last_idx) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              state      <= IDLE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // a wrap during a status LOAD is a fresh request and must survive
      if (tick) hb_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tdc_report_scheduler.sv
// Directed bench for tdc_report_scheduler with HB_CYCLES=1000, MAX_CONSEC=2.
// Accepted bytes are collected by a monitor; each test compares them against
// hand-computed frames.
module tb_tdc_report_scheduler;

  logic clk_100m = 1'b0;
  logic rst_n    = 1'b0;

  int checks = 0;
  int errors = 0;
  int base   = 0;
  logic [7:0] rx_q [$];

  always #5 clk_100m = ~clk_100m;

  tdc_report_scheduler_if bus ();

  tdc_report_scheduler #(
    .HB_CYCLES  (1000),
    .MAX_CONSEC (2)
  ) dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  // collect every accepted byte
  always @(posedge clk_100m)
    if (rst_n && bus.tx_valid && bus.tx_ready) rx_q.push_back(bus.tx_data);

  task automatic do_reset();
    @(negedge clk_100m);
    rst_n = 1'b0;
    bus.meas_valid  = 1'b0;
    bus.meas_period = 32'h0;
    bus.tx_ready    = 1'b0;
    repeat (2) @(negedge clk_100m);
    rst_n = 1'b1;
    base  = rx_q.size();
  endtask

  task automatic pulse(input logic [31:0] p);
    @(negedge clk_100m);
    bus.meas_valid  = 1'b1;
    bus.meas_period = p;
    @(negedge clk_100m);
    bus.meas_valid  = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (rx_q.size() < base + n && k < budget) begin
      @(negedge clk_100m);
      k++;
    end
    ok = (rx_q.size() >= base + n);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop_count: got %h expected 0000", bus.drop_count); end
  endtask

  task automatic test_single();
    logic [7:0] exp [6];
    logic [7:0] got;
    int hi;
    exp = '{8'hA5, 8'h00, 8'h00, 8'h12, 8'h34, 8'h83};
    do_reset();
    bus.tx_ready = 1'b1;
    @(negedge clk_100m);
    bus.meas_valid  = 1'b1;
    bus.meas_period = 32'h0000_1234;
    @(negedge clk_100m);
    bus.meas_valid  = 1'b0;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_load_cycle: tx_valid=%b busy=%b expected 0/1", bus.tx_valid, bus.busy);
    end
    @(negedge clk_100m);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
      errors++; $display("FAIL single_first_byte: tx_valid=%b data=%h expected 1/a5", bus.tx_valid, bus.tx_data);
    end
    hi = 1;
    repeat (10) begin
      @(negedge clk_100m);
      if (bus.tx_valid === 1'b1) hi++;
    end
    checks++; if (hi != 6) begin errors++; $display("FAIL single_valid_cycles: got %0d expected 6", hi); end
    checks++; if (rx_q.size() != base + 6) begin errors++; $display("FAIL single_count: got %0d expected 6", rx_q.size() - base); end
    for (int i = 0; i < 6; i++) begin
      got = 8'hxx;
      if (rx_q.size() > base + i) got = rx_q[base + i];
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [6];
    logic [7:0] got;
    logic [7:0] prev_d;
    bit prev_stall;
    int k;
    exp = '{8'hA5, 8'h00, 8'h00, 8'h12, 8'h34, 8'h83};
    do_reset();
    bus.tx_ready = 1'b1;
    pulse(32'h0000_1234);
    prev_stall = 1'b0;
    prev_d = 8'h00;
    k = 0;
    while (rx_q.size() < base + 6 && k < 100) begin
      @(negedge clk_100m);
      k++;
      if (prev_stall) begin
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_d) begin
          errors++; $display("FAIL bp_stable: valid=%b data=%h expected 1/%h", bus.tx_valid, bus.tx_data, prev_d);
        end
      end
      bus.tx_ready = ~bus.tx_ready;
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_d = bus.tx_data;
    end
    bus.tx_ready = 1'b1;
    checks++; if (rx_q.size() != base + 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", rx_q.size() - base); end
    for (int i = 0; i < 6; i++) begin
      got = 8'hxx;
      if (rx_q.size() > base + i) got = rx_q[base + i];
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_drops();
    logic [31:0] per [5];
    logic [7:0] exp [16];
    logic [7:0] got;
    bit ok;
    per = '{32'h1122_3344, 32'h5566_7788, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
    exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hE1,
            8'hA5, 8'h55, 8'h66, 8'h77, 8'h88, 8'h69,
            8'h5A, 8'h00, 8'h03, 8'h59};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_100m);
      bus.meas_valid  = 1'b1;
      bus.meas_period = per[i];
    end
    @(negedge clk_100m);
    bus.meas_valid = 1'b0;
    checks++; if (bus.drop_count !== 16'd3) begin errors++; $display("FAIL drops_count: got %0d expected 3", bus.drop_count); end
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
      errors++; $display("FAIL drops_stalled: valid=%b data=%h expected 1/a5", bus.tx_valid, bus.tx_data);
    end
    bus.tx_ready = 1'b1;
    wait_bytes(16, 1500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drops_timeout: got %0d bytes expected 16", rx_q.size() - base); end
    for (int i = 0; i < 16; i++) begin
      got = 8'hxx;
      if (rx_q.size() > base + i) got = rx_q[base + i];
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL drops_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
    repeat (3) @(negedge clk_100m);
    checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL drops_cleared: got %0d expected 0", bus.drop_count); end
  endtask

  task automatic test_starvation();
    logic [7:0] exp [22];
    logic [7:0] got;
    bit ok;
    exp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'hA4,
            8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'hA7,
            8'h5A, 8'h00, 8'h00, 8'h5A,
            8'hA5, 8'h00, 8'h00, 8'h00, 8'h03, 8'hA6};
    do_reset();
    @(negedge clk_100m);
    bus.meas_valid  = 1'b1;
    bus.meas_period = 32'h1;
    @(negedge clk_100m);
    bus.meas_period = 32'h2;
    @(negedge clk_100m);
    bus.meas_valid  = 1'b0;
    repeat (1100) @(negedge clk_100m);
    bus.tx_ready = 1'b1;
    wait_bytes(7, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL starve_second_frame: got %0d bytes expected 7", rx_q.size() - base); end
    pulse(32'h3);
    wait_bytes(22, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL starve_timeout: got %0d bytes expected 22", rx_q.size() - base); end
    for (int i = 0; i < 22; i++) begin
      got = 8'hxx;
      if (rx_q.size() > base + i) got = rx_q[base + i];
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL starve_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_coincidence();
    logic [7:0] exp [18];
    logic [7:0] got;
    bit ok;
    int k;
    exp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'hB5,
            8'hA5, 8'h00, 8'h00, 8'h00, 8'h20, 8'h85,
            8'hA5, 8'h00, 8'h00, 8'h00, 8'h30, 8'h95};
    do_reset();
    @(negedge clk_100m);
    bus.meas_valid  = 1'b1;
    bus.meas_period = 32'h10;
    @(negedge clk_100m);
    bus.meas_period = 32'h20;
    @(negedge clk_100m);
    bus.meas_valid  = 1'b0;
    bus.tx_ready    = 1'b1;
    k = 0;
    do begin
      @(negedge clk_100m);
      k++;
    end while (bus.busy === 1'b1 && k < 50);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL coin_idle_gap: busy=%b expected 0", bus.busy); end
    @(negedge clk_100m);
    checks++;
    if (bus.busy !== 1'b1 || bus.tx_valid !== 1'b0) begin
      errors++; $display("FAIL coin_load_cycle: busy=%b tx_valid=%b expected 1/0", bus.busy, bus.tx_valid);
    end
    bus.meas_valid  = 1'b1;
    bus.meas_period = 32'h30;
    @(negedge clk_100m);
    bus.meas_valid  = 1'b0;
    checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL coin_no_drop: got %0d expected 0", bus.drop_count); end
    wait_bytes(18, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL coin_timeout: got %0d bytes expected 18", rx_q.size() - base); end
    for (int i = 0; i < 18; i++) begin
      got = 8'hxx;
      if (rx_q.size() > base + i) got = rx_q[base + i];
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL coin_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_hb_during_send();
    logic [7:0] exp [10];
    logic [7:0] got;
    bit ok;
    exp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h5A,
            8'h5A, 8'h00, 8'h00, 8'h5A};
    do_reset();
    pulse(32'h0000_00FF);
    repeat (2100) @(negedge clk_100m);
    checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
      errors++; $display("FAIL hb_stalled: valid=%b data=%h expected 1/a5", bus.tx_valid, bus.tx_data);
    end
    bus.tx_ready = 1'b1;
    wait_bytes(10, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hb_timeout: got %0d bytes expected 10", rx_q.size() - base); end
    repeat (100) @(negedge clk_100m);
    checks++; if (rx_q.size() != base + 10) begin errors++; $display("FAIL hb_single_request: got %0d bytes expected 10", rx_q.size() - base); end
    for (int i = 0; i < 10; i++) begin
      got = 8'hxx;
      if (rx_q.size() > base + i) got = rx_q[base + i];
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL hb_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp [6];
    logic [7:0] got;
    bit ok;
    exp = '{8'hA5, 8'h00, 8'h00, 8'h12, 8'h34, 8'h83};
    do_reset();
    bus.tx_ready = 1'b1;
    pulse(32'hCAFE_BABE);
    wait_bytes(3, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_progress: got %0d bytes expected 3", rx_q.size() - base); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_async: tx_valid=%b expected 0", bus.tx_valid); end
    repeat (2) @(negedge clk_100m);
    rst_n = 1'b1;
    base  = rx_q.size();
    repeat (30) @(negedge clk_100m);
    checks++; if (rx_q.size() != base) begin errors++; $display("FAIL rst_mid_residual: got %0d bytes expected 0", rx_q.size() - base); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: tx_valid=%b expected 0", bus.tx_valid); end
    pulse(32'h0000_1234);
    wait_bytes(6, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_timeout: got %0d bytes expected 6", rx_q.size() - base); end
    for (int i = 0; i < 6; i++) begin
      got = 8'hxx;
      if (rx_q.size() > base + i) got = rx_q[base + i];
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL rst_mid_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
  endtask

  initial begin
    bus.meas_valid  = 1'b0;
    bus.meas_period = 32'h0;
    bus.tx_ready    = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_drops();
    test_starvation();
    test_coincidence();
    test_hb_during_send();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_report_scheduler.md
Name: tdc_report_scheduler

Overview:
Sits between the TDC measurement core and the UART byte transmitter, in the clk_100m domain.
- Captures period measurements and frames them into fixed-length byte packets.
- Shares the single UART byte channel between measurement frames and a periodic heartbeat/status frame, with a starvation guard.
- Counts measurements dropped because of transmit backlog.

Parameters:
- HB_CYCLES, 100_000_000, clock cycles between heartbeat requests (1 s at 100 MHz); legal range ≥ 2
- MAX_CONSEC, 8, maximum consecutive measurement frames sent while a heartbeat is pending; legal range ≥ 1

Ports:
- clk_100m  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous, active-low reset
- meas_valid  input  1  single-cycle pulse; meas_period is valid
- meas_period  input  32  rising-edge-to-rising-edge period in clk_100m cycles
- tx_data  output  8  byte to the UART transmitter
- tx_valid  output  1  tx_data valid; held until accepted
- tx_ready  input  1  UART transmitter can accept a byte
- busy  output  1  frame in progress
- drop_count  output  16  current saturating drop counter

Behaviour:
- Reset is asynchronous, active-low (rst_n), clock is clk_100m. On reset:
  - tx_valid=0, tx_data=0x00, busy=0, drop_count=0
  - holding register empty, heartbeat timer=0, hb_pending=0, consec=0, FSM in IDLE
- Reset mid-frame abandons the partial frame; tx_valid drops immediately.
- Holding register (1 entry):
  - meas_valid while empty: capture meas_period, mark full.
  - meas_valid while full: discard the measurement; drop_count += 1, saturating at 0xFFFF.
  - If meas_valid arrives in the same cycle the register is freed (frame load), the new value is captured and no drop is counted.
- Heartbeat timer:
  - Counts 0..HB_CYCLES-1 and wraps.
  - Sets hb_pending on the wrap cycle.
  - An already-pending heartbeat stays a single request; requests are not queued.
- Frame formats, multi-byte fields MSB first, chk = XOR of all preceding bytes in the frame:
  - measurement frame: 0xA5, P[31:24], P[23:16], P[15:8], P[7:0], chk (6 bytes)
  - status frame: 0x5A, D[15:8], D[7:0], chk (4 bytes)
- FSM states IDLE, LOAD, SEND.
  - IDLE, arbitration evaluated each cycle:
    - If hb_pending and (consec == MAX_CONSEC or holding register empty): select status frame.
    - Else if holding register full: select measurement frame.
    - Otherwise remain in IDLE.
  - LOAD (1 cycle), with the frame-buffer snapshot taken this cycle:
    - measurement: copy the holding register into the frame buffer, free the holding register, consec = min(consec+1, MAX_CONSEC).
    - status: snapshot drop_count into the frame buffer, then clear drop_count (an increment in the same cycle makes the result 1), clear hb_pending, consec=0.
    - Compute chk over the frame.
  - SEND: tx_valid=1 with byte[idx].
    - On tx_valid && tx_ready: idx+1.
    - After the last byte is accepted: tx_valid=0, return to IDLE.
- Handshake rules:
  - tx_data stable while tx_valid=1 and tx_ready=0.
  - No bubble between bytes within a frame.
  - Minimum one IDLE cycle between frames.
- busy=1 in LOAD and SEND.
- Latency: first byte is presented 2 cycles after meas_valid when idle (capture, LOAD).

Decomposition:
- Shared package tdc_pkg holds:
  - SYNC_MEAS=8'hA5, SYNC_STAT=8'h5A
  - MEAS_FRAME_LEN=6, STAT_FRAME_LEN=4
  - FSM state enum
- A heartbeat timer sub-module, tdc_tick_gen, is natural: a parameterised period counter with a single-cycle tick output.
- Framing and arbitration stay in this module.

Test Plan:
- Single measurement, tx_ready tied 1: meas_period=0x00001234 → bytes A5 00 00 12 34 83, tx_valid high exactly 6 cycles, first byte 2 cycles after meas_valid.
- Backpressure: same stimulus with tx_ready toggling 1/0 → same byte sequence; tx_data is stable whenever tx_valid=1 and tx_ready=0.
- Drops: tx_ready=0; send 5 meas_valid pulses → first measurement goes to the frame buffer, second to holding, remaining 3 dropped, drop_count=3. Then HB_CYCLES=1000 with tx_ready=1: after both measurement frames, status frame 5A 00 03 59 is sent, and drop_count=0.
- Starvation guard: MAX_CONSEC=2, measurements arriving back-to-back, heartbeat pending → frame order meas, meas, status, meas; no status frame is ever delayed beyond 2 measurement frames.
- Coincidence: meas_valid in the same cycle as the LOAD that frees the holding register → captured, drop_count unchanged. Heartbeat wrap during SEND → one status frame after the current frame.
- Reset mid-frame: assert rst_n=0 after byte 3 is accepted → tx_valid=0 asynchronously. After release, no residual bytes are sent, and the next measurement produces a complete 6-byte frame.
